// File: rtl/patch_seq_ctrl.sv
// rtl/patch_seq_ctrl.sv - patchifier sequencer: start, wait for done, stream every pixel, release buffer
// Optional WAIT watchdog is compiled in when PATCH_SEQ_TIMEOUT_EN is defined.
module patch_seq_ctrl #(
  parameter int PIXEL_WIDTH       = 24,
  parameter int TOTAL_NUM_PATCHES = 16,
  parameter int PATCH_VECTOR_SIZE = 256,
`ifdef PATCH_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES    = 1024,
`endif
  parameter int PIDX_W            = $clog2(TOTAL_NUM_PATCHES),
  parameter int POS_W             = $clog2(PATCH_VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   pf_en,
  output logic                   pf_output_taken,
  input  logic [1:0]             pf_state,
  output logic [PIDX_W-1:0]      rd_patch_idx,
  output logic [POS_W-1:0]       rd_pos_idx,
  input  logic [PIXEL_WIDTH-1:0] rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic [PIDX_W-1:0]      out_patch_idx,
  output logic [POS_W-1:0]       out_pos_idx,
  output logic                   out_last_patch,
  output logic                   out_last_frame,
  output logic                   frame_done,
  output logic                   err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [1:0] PF_IDLE = 2'b00;
  localparam logic [1:0] PF_DONE = 2'b10;

  logic [2:0]        state;
  logic [PIDX_W-1:0] pcnt;
  logic [POS_W-1:0]  qcnt;
  logic              issued_all;
  logic              load;
  logic              accept;
  logic              last_pos;
  logic              last_beat;

  // Status pulses decode straight from the registered state.
  assign busy            = (state != S_IDLE);
  assign pf_en           = (state == S_START);
  assign pf_output_taken = (state == S_RELEASE);
  assign frame_done      = (state == S_FINISH) && (pf_state == PF_IDLE);

  assign rd_patch_idx = pcnt;
  assign rd_pos_idx   = qcnt;

  // A new beat is fetched whenever the output slot is empty or being drained this cycle.
  assign accept    = out_valid && out_ready;
  assign load      = (state == S_STREAM) && (!out_valid || out_ready) && !issued_all;
  assign last_pos  = (qcnt == POS_W'(PATCH_VECTOR_SIZE - 1));
  assign last_beat = last_pos && (pcnt == PIDX_W'(TOTAL_NUM_PATCHES - 1));

`ifdef PATCH_SEQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_expired;

  assign wdog_expired = (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles from zero and latches a sticky error when it runs out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else if (state == S_START) begin
      wdog <= '0;
    end else if (state == S_WAIT) begin
      wdog <= wdog + WDOG_W'(1);
      if (pf_state != PF_DONE && wdog_expired)
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Frame sequencing and patch-major read counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pcnt       <= '0;
      qcnt       <= '0;
      issued_all <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (start) state <= S_START;
        S_START:
          state <= S_WAIT;
        S_WAIT:
          if (pf_state == PF_DONE) begin
            state      <= S_STREAM;
            pcnt       <= '0;
            qcnt       <= '0;
            issued_all <= 1'b0;
          end
`ifdef PATCH_SEQ_TIMEOUT_EN
          else if (wdog_expired) begin
            state <= S_IDLE;
          end
`endif
        S_STREAM:
          if (load) begin
            if (last_pos) begin
              qcnt <= '0;
              pcnt <= pcnt + PIDX_W'(1);
            end else begin
              qcnt <= qcnt + POS_W'(1);
            end
            if (last_beat) begin
              issued_all <= 1'b1;
              state      <= S_DRAIN;
            end
          end
        S_DRAIN:
          if (accept) state <= S_RELEASE;
        S_RELEASE:
          state <= S_FINISH;
        S_FINISH:
          if (pf_state == PF_IDLE) state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  // Single-entry output register: holds the beat until accepted, refills in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_patch_idx  <= '0;
      out_pos_idx    <= '0;
      out_last_patch <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (load) begin
      out_valid      <= 1'b1;
      out_data       <= rd_data;
      out_patch_idx  <= pcnt;
      out_pos_idx    <= qcnt;
      out_last_patch <= last_pos;
      out_last_frame <= last_beat;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule
